serial_multiplier: RTL and testbench

SERIAL_MULTIPLIER -- requirements
Module: serial_multiplier

---
 rtl/serial_mult_pkg.sv | 14 +
 rtl/serial_multiplier_if.sv | 41 ++++
 rtl/serial_mult_dp.sv | 59 +++++
 rtl/serial_multiplier.sv | 97 +++++++++
 tb/tb_serial_multiplier.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/serial_mult_pkg.sv
// Shared types and constants for the serial shift-add multiplier.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : controller states IDLE / BUSY / DONE
package serial_mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_multiplier_if.sv
// Request/result bundle of the serial multiplier.
//   Enable       : start request (master -> slave)
//   multiplicant : unsigned multiplicand, WIDTH bits (master -> slave)
//   multiplier   : unsigned multiplier, WIDTH bits (master -> slave)
//   product      : registered result, 2*WIDTH bits (slave -> master)
//   done         : high while product holds a completed result (slave -> master)
//   busy         : high while an operation runs; present only with SERIAL_MULT_BUSY_EN
interface serial_multiplier_if #(
    parameter int unsigned WIDTH = serial_mult_pkg::DEFAULT_WIDTH
);

    logic                 Enable;
    logic [WIDTH-1:0]     multiplicant;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 done;
`ifdef SERIAL_MULT_BUSY_EN
    logic                 busy;

    modport master (
        output Enable, multiplicant, multiplier,
        input  product, done, busy
    );

    modport slave (
        input  Enable, multiplicant, multiplier,
        output product, done, busy
    );
`else
    modport master (
        output Enable, multiplicant, multiplier,
        input  product, done
    );

    modport slave (
        input  Enable, multiplicant, multiplier,
        output product, done
    );
`endif

endinterface

// File: rtl/serial_mult_dp.sv
// Shift-add datapath: operand, accumulator and step-counter registers.
//   clk, reset   : clock, synchronous active-low reset
//   load         : capture operands, clear accumulator and counter
//   step         : perform one LSB-first shift-add step
//   multiplicant : multiplicand input, WIDTH bits
//   multiplier   : multiplier input, WIDTH bits
//   sum_c        : accumulator value after the current step (combinational)
//   last_c       : current step is the final one (combinational)
module serial_mult_dp
    import serial_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     multiplicant,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   sum_c,
    output logic                 last_c
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;

    // Multiplicand is pre-widened and shifted left each step, so bit i of the
    // original multiplier always meets multiplicant<<i.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= PW'(multiplicant);
            mplier_q <= multiplier;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= sum_c;
            mcand_q  <= {mcand_q[PW-2:0], 1'b0};
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Next accumulator value and final-step detect.
    always_comb begin
        sum_c  = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
        last_c = (cnt_q == CNT_W'(WIDTH - 1));
    end

endmodule

// File: rtl/serial_multiplier.sv
// Serial unsigned multiplier: one shift-add step per clock, WIDTH steps per
// product. Holds the controller FSM and the registered outputs.
//   clk   : clock, rising-edge active
//   reset : synchronous active-low reset
//   bus   : serial_multiplier_if slave (Enable, multiplicant, multiplier,
//           product, done, and busy when SERIAL_MULT_BUSY_EN is defined)
// Optional feature macro: SERIAL_MULT_BUSY_EN adds a registered busy output.
module serial_multiplier
    import serial_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_multiplier_if.slave    bus
);

    localparam int unsigned PW = 2 * WIDTH;

    state_t          state_q;
    logic [PW-1:0]   product_q;
    logic            done_q;
    logic            load_c;
    logic            step_c;
    logic [PW-1:0]   sum_c;
    logic            last_c;
`ifdef SERIAL_MULT_BUSY_EN
    logic            busy_q;
`endif

    // A start is accepted only outside BUSY; BUSY drives one step per cycle.
    always_comb begin
        load_c = (state_q != BUSY) && bus.Enable;
        step_c = (state_q == BUSY);
    end

    serial_mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk          (clk),
        .reset        (reset),
        .load         (load_c),
        .step         (step_c),
        .multiplicant (bus.multiplicant),
        .multiplier   (bus.multiplier),
        .sum_c        (sum_c),
        .last_c       (last_c)
    );

    // Controller and output registers; product only updates on the final step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            product_q <= '0;
            done_q    <= 1'b0;
`ifdef SERIAL_MULT_BUSY_EN
            busy_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.Enable) begin
                        state_q <= BUSY;
                        done_q  <= 1'b0;
`ifdef SERIAL_MULT_BUSY_EN
                        busy_q  <= 1'b1;
`endif
                    end
                end
                BUSY: begin
                    if (last_c) begin
                        state_q   <= DONE;
                        product_q <= sum_c;
                        done_q    <= 1'b1;
`ifdef SERIAL_MULT_BUSY_EN
                        busy_q    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
`ifdef SERIAL_MULT_BUSY_EN
                    busy_q  <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.product = product_q;
    assign bus.done    = done_q;
`ifdef SERIAL_MULT_BUSY_EN
    assign bus.busy    = busy_q;
`endif

endmodule

// File: tb/tb_serial_multiplier.sv
// Self-checking bench for serial_multiplier: directed scenarios plus random
// operand pairs, with expected results queued at start and checked by a
// separate monitor on each rising done.
module tb_serial_multiplier;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;

    typedef struct {
        logic [PW-1:0] prod;
        int            accept_cyc;
        string         name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic done_prev;

    serial_multiplier_if #(.WIDTH(W)) bus ();

    serial_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1 && done_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_product"}, bus.product, e.prod);
                check({e.name, "_latency"}, cyc - e.accept_cyc, W);
            end
        end
        done_prev <= bus.done;
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    // Pulse Enable for one edge; queue the reference product.
    task automatic start(input int a, input int b, input string name, input bit expect_result);
        exp_t e;
        @(negedge clk);
        bus.multiplicant = W'(a);
        bus.multiplier   = W'(b);
        bus.Enable       = 1'b1;
        @(posedge clk);
        #1;
        bus.Enable = 1'b0;
        if (expect_result) begin
            e.prod       = PW'(a * b);
            e.accept_cyc = cyc;
            e.name       = name;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * W + 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int a;
        int b;
        bit saw_done;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        done_prev = 1'b0;
        reset    = 1'b0;
        bus.Enable       = 1'b0;
        bus.multiplicant = '0;
        bus.multiplier   = '0;

        // Reset state
        do_reset(2);
        check("reset_product", bus.product, 0);
        check("reset_done", bus.done, 0);
`ifdef SERIAL_MULT_BUSY_EN
        check("reset_busy", bus.busy, 0);
`endif

        // 15*15, then zero operands
        start(15, 15, "mul_15x15", 1'b1);
        wait_done("mul_15x15");
        start(0, 9, "mul_0x9", 1'b1);
        @(negedge clk);
        check("zero_no_early_done", bus.done, 0);
        wait_done("mul_0x9");
        start(9, 0, "mul_9x0", 1'b1);
        wait_done("mul_9x0");
        check("mul_9x0_done_level", bus.done, 1);

        // 7*3 with operand change and Enable re-pulse mid-operation
        start(7, 3, "mul_7x3", 1'b1);
        @(negedge clk);
        bus.multiplicant = W'(1);
        bus.multiplier   = W'(1);
        bus.Enable       = 1'b1;
        @(posedge clk);
        #1;
        bus.Enable = 1'b0;
        wait_done("mul_7x3");
        repeat (W + 2) @(negedge clk);
        check("mul_7x3_held", bus.product, 21);
        check("mul_7x3_done_held", bus.done, 1);

        // Reset mid-operation aborts without a done pulse
        start(5, 5, "abort", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_done", bus.done, 0);
        check("abort_product", bus.product, 0);
        saw_done = 1'b0;
        repeat (2 * W + 2) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);

        // 6*5 held in DONE, then restart with 4*12
        start(6, 5, "mul_6x5", 1'b1);
        wait_done("mul_6x5");
        repeat (10) @(negedge clk);
        check("hold_product", bus.product, 30);
        check("hold_done", bus.done, 1);
        start(4, 12, "mul_4x12", 1'b1);
        @(negedge clk);
        check("restart_done_drop", bus.done, 0);
        check("restart_product_hidden", bus.product, 30);
`ifdef SERIAL_MULT_BUSY_EN
        check("restart_busy", bus.busy, 1);
`endif
        wait_done("mul_4x12");
`ifdef SERIAL_MULT_BUSY_EN
        check("done_busy_low", bus.busy, 0);
`endif

        // Random operand pairs, reset between runs
        for (int i = 0; i < 50; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            do_reset(1);
            start(a, b, "rand", 1'b1);
            wait_done("rand");
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
